// File: rtl/fsm_multi_if.sv
// rtl/fsm_multi_if.sv - control/status bundle for the multi-channel sequencer
// Ports:
//   en, clr   : enable and soft clear from the controller
//   a         : one control bit per channel
//   k1, k2    : per-channel pulses (Clear->Idle, Stop->Clear)
//   err       : per-channel timeout-abort pulse
//   state     : 2 bits of state code per channel
//   done_cnt  : CNT_W bits of completion count per channel
// master drives en/clr/a; slave (the design) drives the status outputs.
interface fsm_multi_if #(
    parameter int N     = 4,
    parameter int CNT_W = 8
);
    logic                 en;
    logic                 clr;
    logic [N-1:0]         a;
    logic [N-1:0]         k1;
    logic [N-1:0]         k2;
    logic [N-1:0]         err;
    logic [2*N-1:0]       state;
    logic [N*CNT_W-1:0]   done_cnt;

    modport master (
        output en, clr, a,
        input  k1, k2, err, state, done_cnt
    );

    modport slave (
        input  en, clr, a,
        output k1, k2, err, state, done_cnt
    );
endinterface

// File: rtl/fsm_multi.sv
// rtl/fsm_multi.sv - N independent Idle/Start/Stop/Clear sequencers with hold qualification and timeout
// Ports:
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : fsm_multi_if.slave (en, clr, a in; k1, k2, err, state, done_cnt out)
// Parameters: N channels, HOLD qualifying cycles, TIMEOUT (0 = off), CNT_W counter width.
// The interface instance must be built with the same N and CNT_W.
module fsm_multi #(
    parameter int N       = 4,
    parameter int HOLD    = 1,
    parameter int TIMEOUT = 0,
    parameter int CNT_W   = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    fsm_multi_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        STOP  = 2'b10,
        CLEAR = 2'b11
    } state_t;

    localparam int             HOLD_LAST_I = HOLD - 1;
    localparam logic [7:0]     HOLD_LAST   = HOLD_LAST_I[7:0];
    localparam int             TO_LAST_I   = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [15:0]    TO_LAST     = TO_LAST_I[15:0];
    localparam bit             TO_ON       = (TIMEOUT > 0);

    state_t               st_q    [N];
    logic [7:0]           hold_q  [N];
    logic [15:0]          timer_q [N];
    logic [CNT_W-1:0]     cnt_q   [N];
    logic [N-1:0]         k1_q;
    logic [N-1:0]         k2_q;
    logic [N-1:0]         err_q;

    logic [N-1:0]         match;
    logic [N-1:0]         qual;
    logic [N-1:0]         tmo;

    function automatic state_t next_state(input state_t s);
        case (s)
            IDLE:    next_state = START;
            START:   next_state = STOP;
            STOP:    next_state = CLEAR;
            default: next_state = IDLE;
        endcase
    endfunction

    // Idle and Stop wait for a high level, Start and Clear for a low level.
    always_comb begin
        match = '0;
        qual  = '0;
        tmo   = '0;
        for (int i = 0; i < N; i++) begin
            match[i] = (bus.a[i] == ((st_q[i] == IDLE) || (st_q[i] == STOP)));
            qual[i]  = match[i] && (hold_q[i] == HOLD_LAST);
            tmo[i]   = TO_ON && (st_q[i] != IDLE) && (timer_q[i] == TO_LAST);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                st_q[i]    <= IDLE;
                hold_q[i]  <= '0;
                timer_q[i] <= '0;
                cnt_q[i]   <= '0;
            end
            k1_q  <= '0;
            k2_q  <= '0;
            err_q <= '0;
        end else if (bus.clr) begin
            for (int i = 0; i < N; i++) begin
                st_q[i]    <= IDLE;
                hold_q[i]  <= '0;
                timer_q[i] <= '0;
                cnt_q[i]   <= '0;
            end
            k1_q  <= '0;
            k2_q  <= '0;
            err_q <= '0;
        end else if (!bus.en) begin
            // Frozen: only the pulses drop so none can repeat on re-enable.
            k1_q  <= '0;
            k2_q  <= '0;
            err_q <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                k1_q[i]  <= 1'b0;
                k2_q[i]  <= 1'b0;
                err_q[i] <= 1'b0;
                if (qual[i]) begin
                    // A qualified move wins over a timeout on the same edge.
                    st_q[i]    <= next_state(st_q[i]);
                    hold_q[i]  <= '0;
                    timer_q[i] <= '0;
                    if (st_q[i] == STOP) begin
                        k2_q[i] <= 1'b1;
                    end
                    if (st_q[i] == CLEAR) begin
                        k1_q[i] <= 1'b1;
                        if (cnt_q[i] != {CNT_W{1'b1}}) begin
                            cnt_q[i] <= cnt_q[i] + 1'b1;
                        end
                    end
                end else if (tmo[i]) begin
                    st_q[i]    <= IDLE;
                    hold_q[i]  <= '0;
                    timer_q[i] <= '0;
                    err_q[i]   <= 1'b1;
                end else begin
                    hold_q[i]  <= match[i] ? hold_q[i] + 8'd1 : 8'd0;
                    timer_q[i] <= ((st_q[i] == IDLE) || !TO_ON) ? 16'd0 : timer_q[i] + 16'd1;
                end
            end
        end
    end

    always_comb begin
        bus.state    = '0;
        bus.done_cnt = '0;
        for (int i = 0; i < N; i++) begin
            bus.state[2*i +: 2]        = st_q[i];
            bus.done_cnt[CNT_W*i +: CNT_W] = cnt_q[i];
        end
        bus.k1  = k1_q;
        bus.k2  = k2_q;
        bus.err = err_q;
    end

endmodule

// File: tb/tb_fsm_multi.sv
// tb/tb_fsm_multi.sv - directed self-checking bench for fsm_multi
module tb_fsm_multi;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    fsm_multi_if #(.N(4), .CNT_W(8)) i0 ();
    fsm_multi_if #(.N(4), .CNT_W(8)) i1 ();
    fsm_multi_if #(.N(4), .CNT_W(2)) i2 ();

    fsm_multi #(.N(4), .HOLD(1), .TIMEOUT(0), .CNT_W(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(i0.slave));
    fsm_multi #(.N(4), .HOLD(3), .TIMEOUT(0), .CNT_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(i1.slave));
    fsm_multi #(.N(4), .HOLD(1), .TIMEOUT(10), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(i2.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        i0.en = 1'b1; i0.clr = 1'b0; i0.a = 4'b0000;
        i1.en = 1'b1; i1.clr = 1'b0; i1.a = 4'b0000;
        i2.en = 1'b1; i2.clr = 1'b0; i2.a = 4'b0000;
        step();
        step();
        chk("rst_state",    64'(i0.state),    64'h0);
        chk("rst_done",     64'(i0.done_cnt), 64'h0);
        chk("rst_pulses",   64'({i0.k1, i0.k2, i0.err}), 64'h0);
        #3 rst_n = 1'b1;

        // Basic walk on channel 0, HOLD=1
        i0.a = 4'b0001; step();
        chk("w_start", 64'(i0.state), 64'h01);
        i0.a = 4'b0000; step();
        chk("w_stop",  64'(i0.state), 64'h02);
        i0.a = 4'b0001; step();
        chk("w_clear", 64'(i0.state), 64'h03);
        chk("w_k2",    64'(i0.k2),    64'h1);
        chk("w_k1_lo", 64'(i0.k1),    64'h0);
        i0.a = 4'b0000; step();
        chk("w_idle",  64'(i0.state), 64'h00);
        chk("w_k1",    64'(i0.k1),    64'h1);
        chk("w_k2_lo", 64'(i0.k2),    64'h0);
        chk("w_done",  64'(i0.done_cnt), 64'h00000001);
        step();
        chk("w_k1_once", 64'(i0.k1),  64'h0);

        // HOLD=3 on channel 1
        i1.a = 4'b0010; step(); step();
        chk("h_two",   64'(i1.state), 64'h00);
        i1.a = 4'b0000; step();
        chk("h_break", 64'(i1.state), 64'h00);
        i1.a = 4'b0010; step(); step();
        chk("h_two_b", 64'(i1.state), 64'h00);
        step();
        chk("h_third", 64'(i1.state), 64'h04);
        i1.a = 4'b0000;

        // Timeout on channel 2 after 10 cycles in Stop
        i2.a = 4'b0100; step();
        chk("t_start", 64'(i2.state), 64'h10);
        i2.a = 4'b0000; step();
        chk("t_stop",  64'(i2.state), 64'h20);
        for (int k = 0; k < 9; k++) step();
        chk("t_wait",  64'(i2.state), 64'h20);
        chk("t_noerr", 64'(i2.err),   64'h0);
        step();
        chk("t_idle",  64'(i2.state), 64'h00);
        chk("t_err",   64'(i2.err),   64'h4);
        chk("t_nok",   64'({i2.k1, i2.k2}), 64'h0);
        chk("t_done",  64'(i2.done_cnt), 64'h00);
        step();
        chk("t_err_once", 64'(i2.err), 64'h0);

        // Saturating CNT_W=2 counter on channel 3
        for (int c = 1; c <= 5; c++) begin
            i2.a = 4'b1000; step();
            i2.a = 4'b0000; step();
            i2.a = 4'b1000; step();
            i2.a = 4'b0000; step();
            chk($sformatf("s_done%0d", c), 64'(i2.done_cnt[7:6]), 64'((c > 3) ? 3 : c));
            chk($sformatf("s_k1_%0d", c),  64'(i2.k1), 64'h8);
        end
        chk("s_ch2", 64'(i2.done_cnt[5:4]), 64'h0);

        // en=0 freezes channel 0 in Start while A toggles
        i0.a = 4'b0001; step();
        chk("e_start", 64'(i0.state), 64'h01);
        i0.en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            i0.a = (k % 2 == 0) ? 4'b0000 : 4'b1111;
            step();
            chk($sformatf("e_frz%0d", k), 64'(i0.state), 64'h01);
        end
        chk("e_pulses", 64'({i0.k1, i0.k2, i0.err}), 64'h0);
        i0.en = 1'b1; i0.a = 4'b0000; step();
        chk("e_stop",  64'(i0.state), 64'h02);
        i0.a = 4'b0001; step();
        chk("e_clear", 64'(i0.state), 64'h03);

        // clr in Clear with A at the qualifying level
        i0.clr = 1'b1; i0.a = 4'b0000; step();
        chk("c_state", 64'(i0.state),    64'h00);
        chk("c_k1",    64'(i0.k1),       64'h0);
        chk("c_done",  64'(i0.done_cnt), 64'h0);
        i0.clr = 1'b0;

        // Asynchronous reset while in Stop
        i0.a = 4'b0001; step();
        i0.a = 4'b0000; step();
        chk("r_stop", 64'(i0.state), 64'h02);
        #2 rst_n = 1'b0;
        #1;
        chk("r_async_state", 64'(i0.state), 64'h00);
        chk("r_async_out",   64'({i0.k1, i0.k2, i0.err, i0.done_cnt}), 64'h0);
        i0.a = 4'b0001;
        #1 rst_n = 1'b1;
        step();
        chk("r_resume", 64'(i0.state), 64'h01);
        chk("r_nopulse", 64'({i0.k1, i0.k2, i0.err}), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fsm_multi.md
FSM_MULTI -- requirements
Module: fsm_multi

Interface
REQ-001 Parameter N, default 4: number of independent channels, 1..16.
REQ-002 Parameter HOLD, default 1: consecutive cycles A must hold the target level to qualify, 1..255.
REQ-003 Parameter TIMEOUT, default 0: maximum cycles in a non-Idle state before forced return to Idle; 0 disables timeout; maximum 65535.
REQ-004 Parameter CNT_W, default 8: width of each per-channel completion counter, 1..16.
REQ-005 Clock  in  1  single clock; all state changes on its rising edge.
REQ-006 Reset  in  1  asynchronous active-low reset.
REQ-007 en  in  1  synchronous enable; low freezes all channel state, hold counters and timers.
REQ-008 clr  in  1  synchronous soft clear of all channels; overrides en.
REQ-009 A  in  N  per-channel control input; bit i drives channel i.
REQ-010 K1  out  N  per-channel registered one-cycle pulse on Clear->Idle.
REQ-011 K2  out  N  per-channel registered one-cycle pulse on Stop->Clear.
REQ-012 err  out  N  per-channel registered one-cycle pulse on timeout abort.
REQ-013 state  out  2N  per-channel state code; bits [2i+1:2i] belong to channel i.
REQ-014 done_cnt  out  N*CNT_W  per-channel completion counters; bits [CNT_W*i+CNT_W-1:CNT_W*i] belong to channel i.

Function
REQ-015 Each channel SHALL implement four states: Idle=2'b00, Start=2'b01, Stop=2'b10, Clear=2'b11; channels SHALL be fully independent.
REQ-016 Target level per state: Idle high, Start low, Stop high, Clear low.
REQ-017 A per-channel hold counter SHALL increment each enabled cycle A[i] equals the target level, and SHALL reset to 0 on any cycle A[i] differs from it or the state changes.
REQ-018 A transition SHALL occur on the edge where A[i] equals the target and the hold counter equals HOLD-1; with HOLD=1 the state changes on the first edge sampling the target level.
REQ-019 Transitions: Idle->Start, Start->Stop, Stop->Clear, Clear->Idle, each only on qualification per REQ-018.
REQ-020 K2[i] SHALL be 1 for exactly the first cycle the channel is in Clear; K1[i] SHALL be 1 for exactly the first cycle in Idle after a Clear->Idle transition.
REQ-021 On Clear->Idle, done_cnt for that channel SHALL increment by 1 and saturate at all-ones (no wrap).
REQ-022 If TIMEOUT>0, a per-channel timer SHALL count enabled cycles spent in a non-Idle state and reset to 0 on every state change and whenever in Idle.
REQ-023 When the timer equals TIMEOUT-1 and no qualified transition occurs on that edge, the channel SHALL go to Idle and err[i] SHALL pulse for one cycle; K1, K2 and done_cnt SHALL be unaffected.
REQ-024 A qualified transition SHALL take priority over timeout on the same edge.
REQ-025 When en=0: state, hold counters, timers and done_cnt hold; K1, K2 and err SHALL be 0.
REQ-026 When clr=1 on an edge: all channels go to Idle; hold counters, timers and done_cnt are zeroed; K1, K2 and err are 0 the next cycle, regardless of en or A.
REQ-027 Pulse outputs SHALL never be asserted for two consecutive cycles in the same channel.

Reset
REQ-028 Reset low SHALL immediately, without a clock edge, force every channel to Idle; hold counters, timers and done_cnt to 0; and K1, K2, err to 0.
REQ-029 Reset asserted mid-sequence SHALL abort it with no K1, K2 or err pulse; after release, operation resumes from Idle on the next edge.

Verification
REQ-030 N=4, HOLD=1: A[0] sequence 1,0,1,0 on four edges -> state[1:0] 01,10,11,00; K2[0]=1 in the first Clear cycle; K1[0]=1 in the first Idle cycle; done_cnt[7:0]=1; other channels stay 00.
REQ-031 HOLD=3: A[1] high for 2 cycles then low -> no transition; then high for 3 cycles -> Start on the 3rd edge.
REQ-032 TIMEOUT=10: move channel 2 to Stop, hold A low -> 10 cycles after entering Stop, state returns to 00, err[2] pulses once, done_cnt unchanged.
REQ-033 CNT_W=2: 5 full cycles on channel 3 -> done_cnt saturates at 3.
REQ-034 en=0 for 5 cycles while A toggles -> no state change; clr=1 in Clear state -> Idle with no K1 pulse, counters 0.
REQ-035 Assert Reset mid-edge-free while in Stop -> state 00 immediately, all outputs 0; after release, A=1 -> Start.
